// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with a 2-entry {pc, instr} output buffer
//
// Purpose:
//   Walks fetch_pc through a combinational instruction ROM and queues the
//   fetched words in a 2-entry FIFO for the decode stage. A taken
//   branch/jump (redirect) flushes the FIFO and restarts fetch at the
//   word-aligned target. Sustains one instruction per cycle when decode
//   is always ready.
//
// Build option:
//   FETCH_RANGE_CHECK_EN - when defined, fetches at word addresses >= ROM_WORDS
//   are suppressed and fetch_fault is raised (sticky until redirect or reset).
//   When undefined, fetching continues through any address and fetch_fault is 0.
//
// Ports:
//   clk            in   1   clock, rising edge
//   reset          in   1   synchronous, active-high reset
//   rom_addr       out  5   ROM word address (fetch_pc[6:2])
//   rom_instr      in   32  ROM read data for rom_addr (combinational)
//   out_valid      out  1   head FIFO entry valid
//   out_ready      in   1   decode accepts head entry
//   out_instr      out  32  head entry instruction
//   out_pc         out  32  head entry byte address
//   redirect_valid in   1   flush and refetch from redirect_pc
//   redirect_pc    in   32  redirect target byte address
//   fetch_fault    out  1   fetch beyond ROM_WORDS (range-check build only)

module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 24
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  rom_addr,
  input  logic [31:0] rom_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  // rom_addr is only 5 bits wide, so a larger populated ROM is meaningless.
  if (ROM_WORDS == 0 || ROM_WORDS > 32) begin : g_bad_rom_words
    $error("instr_fetch: ROM_WORDS must be in 1..32");
  end

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic        fetch_blocked;
  logic        pop;
  logic        push;

`ifdef FETCH_RANGE_CHECK_EN
  logic fault_q, fault_d;
  logic out_of_range;

  assign out_of_range  = ({2'b00, fetch_pc_q[31:2]} >= 32'(ROM_WORDS));
  // Once faulted, stay blocked until a redirect clears the flag.
  assign fetch_blocked = out_of_range || fault_q;
  assign fetch_fault   = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) begin
      fault_d = 1'b0;
    end else if (out_of_range) begin
      fault_d = 1'b1;
    end
  end
`else
  assign fetch_blocked = 1'b0;
  assign fetch_fault   = 1'b0;
`endif

  assign rom_addr  = fetch_pc_q[6:2];
  assign out_valid = (count_q != 2'd0);
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;
    pop          = out_valid && out_ready;
    // A full buffer can still accept a new word when the head leaves this cycle.
    push         = !redirect_valid && !fetch_blocked && ((count_q != 2'd2) || pop);

    if (redirect_valid) begin
      count_d    = 2'd0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d    = fetch_pc_q;
            head_instr_d = rom_instr;
          end else begin
            tail_pc_d    = fetch_pc_q;
            tail_instr_d = rom_instr;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_pc_d    = tail_pc_q;
          head_instr_d = tail_instr_q;
          count_d      = count_q - 2'd1;
        end
        2'b11: begin
          // Single entry: new word replaces the departing head directly.
          if (count_q == 2'd1) begin
            head_pc_d    = fetch_pc_q;
            head_instr_d = rom_instr;
          end else begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            tail_pc_d    = fetch_pc_q;
            tail_instr_d = rom_instr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
`ifdef FETCH_RANGE_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
`ifdef FETCH_RANGE_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  // Buffer payload needs no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    head_pc_q    <= head_pc_d;
    head_instr_q <= head_instr_d;
    tail_pc_q    <= tail_pc_d;
    tail_instr_q <= tail_instr_d;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard testbench for instr_fetch
module tb_instr_fetch;
  localparam int ROM_WORDS = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  logic [31:0] rom [32];
  logic [63:0] exp_q [$];

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;
  bit chk_flush = 1'b0;
  bit prev_hold = 1'b0;
  bit prev_stream = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;

  always #5 clk = ~clk;

  assign rom_instr = rom[rom_addr];

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .ROM_WORDS(ROM_WORDS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_instr     (rom_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_fault   (fetch_fault)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Expected instruction stream from a start address: sequential words,
  // ROM indexed modulo 32 words, stopping at the ROM limit in range-check builds.
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] pc;
    logic [4:0]  w;
    exp_q.delete();
    pc = start & ~32'd3;
    for (int i = 0; i < 512; i++) begin
`ifdef FETCH_RANGE_CHECK_EN
      if ((pc >> 2) >= 32'(ROM_WORDS)) break;
`endif
      w = 5'((pc >> 2) % 32);
      exp_q.push_back({pc, rom[w]});
      pc = pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc, input logic [31:0] instr);
    check1({name, "_valid"}, out_valid, 1'b1);
    check32({name, "_pc"}, out_pc, pc);
    check32({name, "_instr"}, out_instr, instr);
  endtask

  // Monitor: pops the scoreboard on every accepted handshake and checks
  // flush, hold-stability and no-bubble behaviour cycle by cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    if (started) begin
      if (chk_flush) begin
        check1("flush_valid", out_valid, 1'b0);
      end else begin
        if (prev_hold) begin
          check1("hold_valid", out_valid, 1'b1);
          check32("hold_pc", out_pc, prev_pc);
          check32("hold_instr", out_instr, prev_instr);
        end
        if (prev_stream) begin
          check1("no_bubble", out_valid || fetch_fault, 1'b1);
        end
      end
      if (!reset && !redirect_valid && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got pc %h instr %h expected no output", out_pc, out_instr);
        end else begin
          e = exp_q.pop_front();
          check32("sb_pc", out_pc, e[63:32]);
          check32("sb_instr", out_instr, e[31:0]);
        end
      end
      chk_flush   = reset || redirect_valid;
      prev_hold   = out_valid && !out_ready && !reset && !redirect_valid;
      prev_stream = out_valid && out_ready && !reset && !redirect_valid;
      prev_pc     = out_pc;
      prev_instr  = out_instr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int r;
    for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 + 32'(i);
    rom[0]  = 32'h2401_0001;
    rom[1]  = 32'h3508_beef;
    rom[2]  = 32'hac08_fff0;
    rom[18] = 32'h0100_0008;
    rom[22] = 32'h0800_0016;
    rom[23] = 32'h0000_1fcd;

    reset = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    load_stream(32'h0);

    // Reset state and first stream.
    tick();
    started = 1'b1;
    sample();
    check1("reset_valid", out_valid, 1'b0);
    check1("reset_fault", fetch_fault, 1'b0);
    check32("reset_rom_addr", 32'(rom_addr), 32'h0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    sample();
    check1("pre_first_valid", out_valid, 1'b0);
    sample();
    expect_out("seq0", 32'h0, 32'h2401_0001);
    sample();
    expect_out("seq1", 32'h4, 32'h3508_beef);
    sample();
    expect_out("seq2", 32'h8, 32'hac08_fff0);

    // Backpressure: buffer fills and holds, then drains without gaps.
    tick();
    reset = 1'b1;
    out_ready = 1'b0;
    load_stream(32'h0);
    tick();
    reset = 1'b0;
    sample();
    sample();
    expect_out("bp_first", 32'h0, 32'h2401_0001);
    repeat (5) sample();
    check32("bp_fetch_hold", 32'(rom_addr), 32'h2);
    expect_out("bp_head_hold", 32'h0, 32'h2401_0001);
    tick();
    out_ready = 1'b1;
    sample();
    sample();
    expect_out("bp_rel1", 32'h4, 32'h3508_beef);
    sample();
    expect_out("bp_rel2", 32'h8, 32'hac08_fff0);

    // Redirect to 0x58.
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h58;
    load_stream(32'h58);
    tick();
    redirect_valid = 1'b0;
    sample();
    check1("redir58_bubble", out_valid, 1'b0);
    sample();
    expect_out("redir58", 32'h58, 32'h0800_0016);

    // Unaligned redirect target.
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h4A;
    load_stream(32'h4A);
    tick();
    redirect_valid = 1'b0;
    sample();
    check1("redir4a_bubble", out_valid, 1'b0);
    sample();
    expect_out("redir4a", 32'h48, 32'h0100_0008);

    // Run to the end of the populated ROM.
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h50;
    load_stream(32'h50);
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      sample();
      if (out_valid && out_pc == 32'h5C) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reach_5c: got no pc 0x5c within 20 cycles expected it presented");
    end
    check32("last_instr", out_instr, 32'h0000_1fcd);
    check32("last_rom_addr", 32'(rom_addr), 32'h18);
`ifdef FETCH_RANGE_CHECK_EN
    check1("fault_before", fetch_fault, 1'b0);
    sample();
    check1("fault_set", fetch_fault, 1'b1);
    check1("fault_valid", out_valid, 1'b0);
`else
    sample();
    expect_out("past_rom", 32'h60, rom[24]);
`endif

    // Reset while full.
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    load_stream(32'h0);
    tick();
    redirect_valid = 1'b0;
    sample();
`ifdef FETCH_RANGE_CHECK_EN
    check1("fault_cleared", fetch_fault, 1'b0);
`endif
    repeat (3) sample();
    expect_out("full_head", 32'h0, 32'h2401_0001);
    tick();
    reset = 1'b1;
    load_stream(32'h0);
    tick();
    reset = 1'b0;
    sample();
    check1("rst_full_valid", out_valid, 1'b0);
    sample();
    expect_out("rst_refetch", 32'h0, 32'h2401_0001);

    // Randomised traffic checked by the scoreboard monitor.
    for (int c = 0; c < 400; c++) begin
      tick();
      reset = 1'b0;
      redirect_valid = 1'b0;
      r = int'($urandom_range(0, 63));
      if (r == 0) begin
        reset = 1'b1;
        load_stream(32'h0);
      end else if (r < 5) begin
        redirect_valid = 1'b1;
`ifdef FETCH_RANGE_CHECK_EN
        redirect_pc = $urandom_range(0, ROM_WORDS * 4 + 8);
`else
        case ($urandom_range(0, 3))
          0: redirect_pc = $urandom;
          1: redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
          default: redirect_pc = $urandom_range(0, 127);
        endcase
`endif
        load_stream(redirect_pc);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    reset = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) sample();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter ROM_WORDS, default 24, number of populated instruction-ROM words (range check only).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rom_addr  output  5  word address to instruction ROM, equal to fetch_pc[6:2].
REQ-006 rom_instr  input  32  combinational ROM read data for rom_addr.
REQ-007 out_valid  output  1  head buffer entry is valid.
REQ-008 out_ready  input  1  decode stage accepts the head entry.
REQ-009 out_instr  output  32  instruction word of the head entry.
REQ-010 out_pc  output  32  byte address of the head entry.
REQ-011 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-012 redirect_pc  input  32  redirect target byte address.
REQ-013 fetch_fault  output  1  fetch beyond ROM_WORDS (Configuration only).

Function
REQ-014 fetch_pc SHALL be a 32-bit register; rom_addr SHALL be driven combinationally from fetch_pc[6:2].
REQ-015 The block SHALL hold a 2-entry FIFO of {pc, instr}; out_valid = (count != 0); out_instr/out_pc = head entry.
REQ-016 Pop SHALL occur on a cycle with out_valid && out_ready.
REQ-017 Push SHALL occur when no redirect, no fault, and (count < 2 or pop this cycle); entry = {fetch_pc, rom_instr}; fetch_pc <= fetch_pc + 4.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged, including when full.
REQ-019 When full with no pop, fetch_pc and FIFO contents SHALL hold.
REQ-020 Fetch-to-output latency SHALL be 1 cycle: an instruction pushed at edge N is at out_* after edge N.
REQ-021 Sustained throughput with out_ready=1 SHALL be one instruction per cycle, no bubbles.
REQ-022 redirect_valid SHALL take priority over push and pop: count <= 0, fetch_pc <= {redirect_pc[31:2], 2'b00}, no push that cycle.
REQ-023 After a redirect at edge N, out_valid SHALL be 0 after edge N and the target SHALL be at out_* after edge N+1.
REQ-024 Entries fetched before a redirect SHALL never be presented after it.
REQ-025 fetch_pc SHALL wrap modulo 2^32; rom_addr wraps within 32 words.
REQ-026 out_instr/out_pc SHALL hold stable while out_valid && !out_ready.

Reset
REQ-027 On reset: fetch_pc <= RESET_PC, count <= 0, out_valid = 0, fetch_fault = 0, FIFO data don't-care.
REQ-028 Reset SHALL take priority over redirect and any in-flight push or pop; first push occurs on the first non-reset edge.

Configuration
REQ-029 Macro FETCH_RANGE_CHECK_EN defined: if fetch_pc[31:2] >= ROM_WORDS, no push; fetch_fault <= 1, sticky until redirect or reset; buffered entries still drain.
REQ-030 Macro undefined: no range check, fetch_fault tied 0, fetching continues through any address.

Verification
REQ-031 Reset, out_ready=1 -> out_instr 24010001/pc 0, 3508beef/pc 4, ac08fff0/pc 8 on consecutive cycles.
REQ-032 out_ready=0 for 5 cycles after first valid -> count 2, fetch_pc 8, out_instr holds 24010001; release -> 3508beef, ac08fff0, no gap.
REQ-033 redirect_pc=0x58 -> out_valid 0 one cycle, then 08000016/pc 0x58; pre-redirect entries never appear.
REQ-034 redirect_pc=0x4A -> aligned to 0x48, out_instr 01000008/pc 0x48.
REQ-035 With macro, run to pc 0x5C: 00001fcd presented, then fetch_fault=1, out_valid 0; without macro pc 0x60 fetched with rom_addr 0x18.
REQ-036 Reset asserted with count 2 -> out_valid 0 after edge; after release 24010001/pc 0 presented again.
